// File: rtl/rom_port_arbiter.sv
// Shares one fixed-latency ROM read port between IFU and LSU, one read outstanding.
// Optional ROM_ARB_RR_EN: round-robin tie-break instead of fixed LSU-over-IFU priority.
module rom_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [ADDR_W-1:0] ifu_addr_i,
  output logic              ifu_rsp_valid_o,
  input  logic              ifu_rsp_ready_i,
  output logic [DATA_W-1:0] ifu_rsp_data_o,
  output logic              ifu_rsp_err_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  output logic              lsu_rsp_valid_o,
  input  logic              lsu_rsp_ready_i,
  output logic [DATA_W-1:0] lsu_rsp_data_o,
  output logic              lsu_rsp_err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(LAT - 1);

  state_t            state;
  logic              owner_lsu;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
`ifdef ROM_ARB_RR_EN
  logic              last_ifu;
`endif

  logic              idle_act;
  logic              grant_lsu;
  logic              grant_ifu;
  logic              hs;
  logic              aligned;
  logic              rsp_ack;
  logic [ADDR_W-1:0] sel_addr;

  // Grants are gated by rst_i so nothing is offered while reset is held.
  always_comb begin
    idle_act  = rst_i && (state == IDLE);
`ifdef ROM_ARB_RR_EN
    grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || last_ifu);
`else
    grant_lsu = lsu_req_valid_i;
`endif
    grant_ifu = ifu_req_valid_i && !grant_lsu;
    hs        = idle_act && (grant_lsu || grant_ifu);
    sel_addr  = grant_lsu ? lsu_addr_i : ifu_addr_i;
    aligned   = (sel_addr[1:0] == 2'b00);
    rsp_ack   = owner_lsu ? lsu_rsp_ready_i : ifu_rsp_ready_i;
  end

  assign ifu_req_ready_o = idle_act && grant_ifu;
  assign lsu_req_ready_o = idle_act && grant_lsu;
  assign mem_req_o       = hs && aligned;
  assign mem_addr_o      = mem_req_o ? sel_addr : '0;

  assign ifu_rsp_valid_o = (state == RESP) && !owner_lsu;
  assign lsu_rsp_valid_o = (state == RESP) && owner_lsu;
  assign ifu_rsp_data_o  = ifu_rsp_valid_o ? data_q : '0;
  assign ifu_rsp_err_o   = ifu_rsp_valid_o && err_q;
  assign lsu_rsp_data_o  = lsu_rsp_valid_o ? data_q : '0;
  assign lsu_rsp_err_o   = lsu_rsp_valid_o && err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      cnt       <= 2'd0;
      data_q    <= '0;
      err_q     <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_ifu  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            owner_lsu <= grant_lsu;
`ifdef ROM_ARB_RR_EN
            last_ifu  <= grant_ifu;
`endif
            if (aligned) begin
              cnt   <= 2'd0;
              state <= WAIT;
            end else begin
              // Misaligned: answer immediately with an error, never touch the ROM.
              data_q <= '0;
              err_q  <= 1'b1;
              state  <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == LAST_CNT) begin
            data_q <= mem_rdata_i;
            err_q  <= 1'b0;
            state  <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: instance a (LAT=1) for arbitration/timing/reset, instance b (LAT=3) for backpressure.
module tb_rom_port_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic        a_ifu_v, a_ifu_rdy, a_ifu_rv, a_ifu_rr, a_ifu_re;
  logic [31:0] a_ifu_addr, a_ifu_rd;
  logic        a_lsu_v, a_lsu_rdy, a_lsu_rv, a_lsu_rr, a_lsu_re;
  logic [31:0] a_lsu_addr, a_lsu_rd;
  logic        a_mreq;
  logic [31:0] a_maddr, a_mrdata;

  logic        b_ifu_v, b_ifu_rdy, b_ifu_rv, b_ifu_rr, b_ifu_re;
  logic [31:0] b_ifu_addr, b_ifu_rd;
  logic        b_lsu_v, b_lsu_rdy, b_lsu_rv, b_lsu_rr, b_lsu_re;
  logic [31:0] b_lsu_addr, b_lsu_rd;
  logic        b_mreq;
  logic [31:0] b_maddr, b_mrdata;
  logic [31:0] b_p0, b_p1, b_p2;

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(a_ifu_v), .ifu_req_ready_o(a_ifu_rdy), .ifu_addr_i(a_ifu_addr),
    .ifu_rsp_valid_o(a_ifu_rv), .ifu_rsp_ready_i(a_ifu_rr), .ifu_rsp_data_o(a_ifu_rd),
    .ifu_rsp_err_o(a_ifu_re),
    .lsu_req_valid_i(a_lsu_v), .lsu_req_ready_o(a_lsu_rdy), .lsu_addr_i(a_lsu_addr),
    .lsu_rsp_valid_o(a_lsu_rv), .lsu_rsp_ready_i(a_lsu_rr), .lsu_rsp_data_o(a_lsu_rd),
    .lsu_rsp_err_o(a_lsu_re),
    .mem_req_o(a_mreq), .mem_addr_o(a_maddr), .mem_rdata_i(a_mrdata)
  );

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(b_ifu_v), .ifu_req_ready_o(b_ifu_rdy), .ifu_addr_i(b_ifu_addr),
    .ifu_rsp_valid_o(b_ifu_rv), .ifu_rsp_ready_i(b_ifu_rr), .ifu_rsp_data_o(b_ifu_rd),
    .ifu_rsp_err_o(b_ifu_re),
    .lsu_req_valid_i(b_lsu_v), .lsu_req_ready_o(b_lsu_rdy), .lsu_addr_i(b_lsu_addr),
    .lsu_rsp_valid_o(b_lsu_rv), .lsu_rsp_ready_i(b_lsu_rr), .lsu_rsp_data_o(b_lsu_rd),
    .lsu_rsp_err_o(b_lsu_re),
    .mem_req_o(b_mreq), .mem_addr_o(b_maddr), .mem_rdata_i(b_mrdata)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    rom = (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1234_5678);
  endfunction

  // ROM models: data is valid only exactly LAT cycles after the strobe, junk otherwise.
  logic [31:0] a_pipe;
  always @(posedge clk) begin
    a_pipe <= a_mreq ? rom(a_maddr) : 32'hDEAD_BEEF;
    b_p0   <= b_mreq ? rom(b_maddr) : 32'hDEAD_BEEF;
    b_p1   <= b_p0;
    b_p2   <= b_p1;
  end
  assign a_mrdata = a_pipe;
  assign b_mrdata = b_p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_a_quiet(input string tag);
    chk(tag, {a_ifu_rdy, a_lsu_rdy, a_mreq, a_ifu_rv, a_lsu_rv, a_ifu_re, a_lsu_re}, 0);
    chk({tag, "_dat"}, |{a_ifu_rd, a_lsu_rd, a_maddr}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0004; a_ifu_rr = 1'b1;
    a_lsu_v = 1'b1; a_lsu_addr = 32'h8000_0100; a_lsu_rr = 1'b1;
    b_ifu_v = 1'b0; b_ifu_addr = 32'h0; b_ifu_rr = 1'b1;
    b_lsu_v = 1'b0; b_lsu_addr = 32'h0; b_lsu_rr = 1'b1;

    // Reset held with both requesters valid.
    repeat (3) begin
      tick();
      chk_a_quiet("rst_hold");
    end

    // Release: LSU wins the tie on the first edge.
    rst = 1'b1; settle();
    chk("rel_rdy", {a_lsu_rdy, a_ifu_rdy, a_mreq}, 3'b101);
    chk("rel_addr", a_maddr, 32'h8000_0100);
    tick(); a_lsu_v = 1'b0; settle();
    chk("pair_wait", {a_ifu_rdy, a_lsu_rdy, a_mreq, a_ifu_rv, a_lsu_rv}, 0);
    tick(); settle();
    chk("pair_lsu_rsp", {a_lsu_rv, a_ifu_rv, a_lsu_re}, 3'b100);
    chk("pair_lsu_dat", a_lsu_rd, 32'h9234_5778);
    tick(); settle();
    chk("pair_ifu_gnt", {a_ifu_rdy, a_lsu_rdy, a_mreq}, 3'b101);
    chk("pair_ifu_addr", a_maddr, 32'h8000_0004);
    tick(); a_ifu_v = 1'b0; settle();
    tick(); settle();
    chk("pair_ifu_rsp", {a_ifu_rv, a_lsu_rv, a_ifu_re}, 3'b100);
    chk("pair_ifu_dat", a_ifu_rd, 32'h9234_567C);
    tick();

    // IFU fetch timing, LAT=1.
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0000; settle();
    chk("fetch_c0", {a_ifu_rdy, a_mreq}, 2'b11);
    chk("fetch_c0_addr", a_maddr, 32'h8000_0000);
    tick(); a_ifu_v = 1'b0; settle();
    chk("fetch_c1", a_ifu_rv, 1'b0);
    tick(); settle();
    chk("fetch_c2", {a_ifu_rv, a_ifu_re}, 2'b10);
    chk("fetch_c2_dat", a_ifu_rd, 32'h0000_0413);
    tick();

    // Misaligned IFU address.
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0002; settle();
    chk("mis_c0", {a_ifu_rdy, a_mreq}, 2'b10);
    tick(); a_ifu_v = 1'b0; settle();
    chk("mis_c1", {a_ifu_rv, a_ifu_re, a_mreq}, 3'b110);
    chk("mis_c1_dat", a_ifu_rd, 32'h0);
    tick();

    // Tie after an IFU grant goes to LSU in both modes; then a repeat tie.
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0004;
    a_lsu_v = 1'b1; a_lsu_addr = 32'h8000_0100; settle();
    chk("tie1_gnt", {a_lsu_rdy, a_ifu_rdy}, 2'b10);
    tick(); a_lsu_addr = 32'h8000_0008; settle();
    tick(); settle();
    chk("tie1_dat", a_lsu_rd, 32'h9234_5778);
    tick(); settle();
`ifdef ROM_ARB_RR_EN
    chk("tie2_gnt", {a_lsu_rdy, a_ifu_rdy}, 2'b01);
    chk("tie2_addr", a_maddr, 32'h8000_0004);
`else
    chk("tie2_gnt", {a_lsu_rdy, a_ifu_rdy}, 2'b10);
    chk("tie2_addr", a_maddr, 32'h8000_0008);
`endif
    tick(); a_ifu_v = 1'b0; a_lsu_v = 1'b0; settle();
    tick(); settle();
`ifdef ROM_ARB_RR_EN
    chk("tie2_rsp", {a_ifu_rv, a_lsu_rv}, 2'b10);
    chk("tie2_dat", a_ifu_rd, 32'h9234_567C);
`else
    chk("tie2_rsp", {a_ifu_rv, a_lsu_rv}, 2'b01);
    chk("tie2_dat", a_lsu_rd, 32'h9234_5670);
`endif
    tick();

    // Backpressure on instance b, LAT=3.
    b_lsu_v = 1'b1; b_lsu_addr = 32'h8000_0100; b_lsu_rr = 1'b0;
    b_ifu_v = 1'b1; b_ifu_addr = 32'h8000_0004; settle();
    chk("bp_gnt", {b_lsu_rdy, b_ifu_rdy, b_mreq}, 3'b101);
    tick(); b_lsu_v = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_wait", {b_ifu_rdy, b_lsu_rv, b_mreq}, 0);
      tick(); settle();
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {b_lsu_rv, b_ifu_rdy, b_ifu_rv, b_lsu_re}, 4'b1000);
      chk("bp_hold_dat", b_lsu_rd, 32'h9234_5778);
      tick(); settle();
    end
    b_lsu_rr = 1'b1; settle();
    chk("bp_release", {b_lsu_rv, b_ifu_rdy}, 2'b10);
    tick(); settle();
    chk("bp_idle", {b_ifu_rdy, b_mreq, b_lsu_rv}, 3'b110);
    chk("bp_idle_addr", b_maddr, 32'h8000_0004);
    tick(); b_ifu_v = 1'b0; settle();
    repeat (3) tick();
    settle();
    chk("bp_ifu_rsp", {b_ifu_rv, b_ifu_re}, 2'b10);
    chk("bp_ifu_dat", b_ifu_rd, 32'h9234_567C);
    tick();

    // Reset mid-operation: a in WAIT, b holding a response.
    b_lsu_v = 1'b1; b_lsu_addr = 32'h8000_0000; b_lsu_rr = 1'b0; settle();
    tick(); b_lsu_v = 1'b0;
    tick(); tick();
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0000; settle();
    chk("mid_a_gnt", {a_ifu_rdy, a_mreq}, 2'b11);
    tick(); a_ifu_v = 1'b0; settle();
    chk("mid_b_pre", b_lsu_rv, 1'b1);
    rst = 1'b0; #1;
    chk_a_quiet("mid_rst_a");
    chk("mid_rst_b", {b_lsu_rv, b_lsu_re}, 0);
    chk("mid_rst_b_dat", b_lsu_rd, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_none", {a_ifu_rv, a_lsu_rv, b_ifu_rv, b_lsu_rv}, 0);
    end
    a_ifu_v = 1'b1; a_ifu_addr = 32'h8000_0004; settle();
    chk("post_rst_gnt", {a_ifu_rdy, a_mreq}, 2'b11);
    tick(); a_ifu_v = 1'b0; settle();
    tick(); settle();
    chk("post_rst_rsp", {a_ifu_rv, a_ifu_re}, 2'b10);
    chk("post_rst_dat", a_ifu_rd, 32'h9234_567C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
